// File: rtl/fcmp_issue.sv
`default_nettype none
// ============================================================================
// Module      : fcmp_issue
// Description : Issue sequencer for the FPU compare pipe. Maps feq/flt/fle onto
//               a single x1<=x2 pipe and queues 0/1 results with their tags.
// Revision    : 1.0 - initial release
// ============================================================================
module fcmp_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    output logic             cmp_valid,
    output logic [31:0]      cmp_x1,
    output logic [31:0]      cmp_x2,
    input  logic [31:0]      cmp_y,
    input  logic             cmp_out_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_result,
    output logic             err_unexp,
    output logic             err_illegal
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_PASS2 = 1'b1;

    localparam logic [1:0] c_OP_FEQ = 2'b00;
    localparam logic [1:0] c_OP_FLT = 2'b01;
    localparam logic [1:0] c_OP_FLE = 2'b10;
    localparam logic [1:0] c_OP_ILL = 2'b11;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               w_accept;
    logic               w_issue;
    logic [31:0]        w_issue_x1;
    logic [31:0]        w_issue_x2;
    logic               r_cmp_valid;
    logic [31:0]        r_cmp_x1;
    logic [31:0]        r_cmp_x2;

    logic               r_pend_valid;
    logic [1:0]         r_pend_op;
    logic [TAG_W-1:0]   r_pend_tag;
    logic               r_pend_first;
    logic               r_partial;
    logic               r_rst_d;
    logic               r_err_unexp;
    logic               r_err_illegal;

    logic               w_ret;
    logic               w_ret_ok;
    logic               w_ret_unexp;
    logic               w_push;
    logic               w_res;
    logic               w_pop;

    logic [TAG_W:0]     r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_credit_used;
    logic               w_unused;

    assign w_unused = ^cmp_y[31:1];

    // One pending record at a time: the next request waits until the previous result lands.
    assign w_credit_used = r_count + c_CNT_W'(r_pend_valid);
    assign in_ready = !rst && (r_state == c_ST_IDLE) && !r_pend_valid
                      && (w_credit_used < c_CNT_W'(DEPTH));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept && in_op == c_OP_FEQ) w_state_nxt = c_ST_PASS2;
            c_ST_PASS2: w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Second feq pass reuses the first-pass operands, swapped.
    always_comb begin
        w_issue    = 1'b0;
        w_issue_x1 = r_cmp_x1;
        w_issue_x2 = r_cmp_x2;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    case (in_op)
                        c_OP_FLE, c_OP_FEQ: begin
                            w_issue    = 1'b1;
                            w_issue_x1 = in_x1;
                            w_issue_x2 = in_x2;
                        end
                        c_OP_FLT: begin
                            w_issue    = 1'b1;
                            w_issue_x1 = in_x2;
                            w_issue_x2 = in_x1;
                        end
                        default: w_issue = 1'b0;
                    endcase
                end
            end
            c_ST_PASS2: begin
                w_issue    = 1'b1;
                w_issue_x1 = r_cmp_x2;
                w_issue_x2 = r_cmp_x1;
            end
            default: w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_cmp_valid <= 1'b0;
            r_cmp_x1    <= '0;
            r_cmp_x2    <= '0;
        end else begin
            r_cmp_valid <= w_issue;
            r_cmp_x1    <= w_issue_x1;
            r_cmp_x2    <= w_issue_x2;
        end
    end

    assign cmp_valid = r_cmp_valid;
    assign cmp_x1    = r_cmp_x1;
    assign cmp_x2    = r_cmp_x2;

    // Returns sampled in the first cycle out of reset belong to pre-reset issues.
    assign w_ret       = cmp_out_valid && !r_rst_d;
    assign w_ret_ok    = w_ret && r_pend_valid && (r_pend_op != c_OP_ILL);
    assign w_ret_unexp = w_ret && !(r_pend_valid && (r_pend_op != c_OP_ILL));

    always_comb begin
        w_push = 1'b0;
        w_res  = 1'b0;
        if (r_pend_valid && r_pend_op == c_OP_ILL) begin
            w_push = 1'b1;
        end else if (w_ret_ok) begin
            case (r_pend_op)
                c_OP_FLE: begin
                    w_push = 1'b1;
                    w_res  = cmp_y[0];
                end
                c_OP_FLT: begin
                    w_push = 1'b1;
                    w_res  = ~cmp_y[0];
                end
                c_OP_FEQ: begin
                    w_push = !r_pend_first;
                    w_res  = r_partial & cmp_y[0];
                end
                default: w_push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        r_rst_d <= rst;
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_op     <= c_OP_FEQ;
            r_pend_tag    <= '0;
            r_pend_first  <= 1'b0;
            r_partial     <= 1'b0;
            r_err_unexp   <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_op    <= in_op;
                r_pend_tag   <= in_tag;
                r_pend_first <= (in_op == c_OP_FEQ);
            end else if (w_push) begin
                r_pend_valid <= 1'b0;
            end
            if (w_ret_ok && r_pend_op == c_OP_FEQ && r_pend_first) begin
                r_partial    <= cmp_y[0];
                r_pend_first <= 1'b0;
            end
            if (w_accept && in_op == c_OP_ILL) r_err_illegal <= 1'b1;
            if (w_ret_unexp) r_err_unexp <= 1'b1;
        end
    end

    assign err_unexp   = r_err_unexp;
    assign err_illegal = r_err_illegal;

    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_pend_tag, w_res};
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_tag    = out_valid ? r_mem[r_rd_ptr][TAG_W:1] : '0;
    assign out_result = {31'b0, out_valid & r_mem[r_rd_ptr][0]};

endmodule
`default_nettype wire

// File: tb/tb_fcmp_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcmp_issue
// Description : Self-checking bench for fcmp_issue with a 1-cycle compare pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fcmp_issue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             sys_clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic             cmp_valid;
    logic [31:0]      cmp_x1;
    logic [31:0]      cmp_x2;
    logic [31:0]      cmp_y;
    logic             cmp_out_valid;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_result;
    logic             err_unexp;
    logic             err_illegal;

    logic             pipe_v = 1'b0;
    logic [31:0]      pipe_y = '0;
    logic             inj = 1'b0;
    bit               rnd_ready = 1'b0;
    int               total = 0;
    int               bad = 0;
    logic [TAG_W:0]   exp_q[$];

    always #5 sys_clk = ~sys_clk;

    fcmp_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
        .in_x1(in_x1), .in_x2(in_x2),
        .cmp_valid(cmp_valid), .cmp_x1(cmp_x1), .cmp_x2(cmp_x2),
        .cmp_y(cmp_y), .cmp_out_valid(cmp_out_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_result(out_result), .err_unexp(err_unexp), .err_illegal(err_illegal)
    );

    // Total order of non-NaN singles; -0 sorts below +0.
    function automatic logic [31:0] ord_key(input logic [31:0] f);
        return f[31] ? ~f : (f | 32'h8000_0000);
    endfunction

    function automatic logic ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b10:   return ord_key(a) <= ord_key(b);
            2'b01:   return ord_key(a) <  ord_key(b);
            2'b00:   return a == b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 6))
                0: r = 32'h3F80_0000;
                1: r = 32'h4000_0000;
                2: r = 32'hBF80_0000;
                3: r = 32'h0000_0000;
                4: r = 32'h8000_0000;
                5: r = 32'h4040_0000;
                default: r = 32'hC000_0000;
            endcase
        end
        if (r[30:23] == 8'hFF) r[30] = 1'b0;
        return r;
    endfunction

    // Compare pipe: one cycle, y all-ones when x1 <= x2.
    always @(posedge sys_clk) begin
        pipe_v <= cmp_valid;
        pipe_y <= (ord_key(cmp_x1) <= ord_key(cmp_x2)) ? 32'hFFFF_FFFF : 32'h0;
    end
    assign cmp_out_valid = pipe_v | inj;
    assign cmp_y = pipe_y;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        in_valid = 1'b1; in_op = op; in_tag = tag; in_x1 = a; in_x2 = b;
        while (!in_ready && g < 300) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            exp_q.push_back({tag, ref_result(op, a, b)});
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 400) begin
            tick();
            g++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Scoreboard on every pop.
    initial begin
        logic [TAG_W:0] e;
        forever begin
            @(negedge sys_clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pop_extra: got tag %0d expected no entry", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_tag", 32'(out_tag), 32'(e[TAG_W:1]));
                    chk("pop_result", out_result, {31'b0, e[0]});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] x1;
        logic [31:0] x2;
        int          lat;
        int          ncv;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n;
        int cv;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        vt[0] = '{2'b10, 5'd3,  32'h3F800000, 32'h40000000, 32'd1, 32'h3F800000, 32'h40000000, 3, 1};
        vt[1] = '{2'b10, 5'd4,  32'h40000000, 32'h3F800000, 32'd0, 32'h40000000, 32'h3F800000, 3, 1};
        vt[2] = '{2'b01, 5'd5,  32'hBF800000, 32'h3F800000, 32'd1, 32'h3F800000, 32'hBF800000, 3, 1};
        vt[3] = '{2'b01, 5'd6,  32'h40000000, 32'h40000000, 32'd0, 32'h40000000, 32'h40000000, 3, 1};
        vt[4] = '{2'b00, 5'd8,  32'h40400000, 32'h40400000, 32'd1, 32'h40400000, 32'h40400000, 4, 2};
        vt[5] = '{2'b00, 5'd9,  32'h3F800000, 32'h40000000, 32'd0, 32'h3F800000, 32'h40000000, 4, 2};
        vt[6] = '{2'b11, 5'd7,  32'h00000001, 32'h00000002, 32'd0, 32'h0,        32'h0,        2, 0};
        vt[7] = '{2'b00, 5'd10, 32'h00000000, 32'h80000000, 32'd0, 32'h00000000, 32'h80000000, 4, 2};

        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_tag = '0;
        in_x1 = '0; in_x2 = '0; out_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        tick();
        chk("rst_cmp_valid", 32'(cmp_valid), 0);
        chk("rst_cmp_x1", cmp_x1, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_errs", {30'b0, err_unexp, err_illegal}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Directed vectors with an empty FIFO
        for (int i = 0; i < 8; i++) begin
            send(vt[i].op, vt[i].tag, vt[i].a, vt[i].b);
            n = 1;
            cv = 0;
            if (vt[i].op != 2'b11) begin
                chk("x1_pass1", cmp_x1, vt[i].x1);
                chk("x2_pass1", cmp_x2, vt[i].x2);
            end
            while (!out_valid && n < 12) begin
                if (cmp_valid) cv++;
                tick();
                n++;
                if (n == 2 && vt[i].op == 2'b00) begin
                    chk("x1_pass2", cmp_x1, vt[i].x2);
                    chk("x2_pass2", cmp_x2, vt[i].x1);
                    chk("in_ready_pass2", 32'(in_ready), 0);
                end
            end
            chk("latency", n, vt[i].lat);
            chk("cmp_cycles", cv, vt[i].ncv);
            chk("result", out_result, vt[i].res);
            chk("tag", 32'(out_tag), 32'(vt[i].tag));
            tick();
        end
        chk("err_illegal_set", 32'(err_illegal), 1);
        chk("err_unexp_clear", 32'(err_unexp), 0);

        // Fill FIFO with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(2'b10, 5'(i), 32'h3F800000, 32'h40000000);
        for (int i = 0; i < 5; i++) begin
            chk("full_in_ready", 32'(in_ready), 0);
            tick();
        end
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_head", 32'(out_tag), 0);
        out_ready = 1'b1;
        chk("pop_cycle_in_ready", 32'(in_ready), 0);
        tick();
        chk("after_pop_in_ready", 32'(in_ready), 1);
        repeat (3) tick();
        chk("full_drained", 32'(out_valid), 0);

        // Push and pop in the same cycle at count 2
        out_ready = 1'b0;
        send(2'b10, 5'd10, 32'h3F800000, 32'h40000000);
        send(2'b01, 5'd11, 32'h3F800000, 32'h40000000);
        repeat (3) tick();
        chk("pp_head", 32'(out_tag), 10);
        send(2'b10, 5'd12, 32'h40000000, 32'h3F800000);
        tick();
        out_ready = 1'b1;
        tick();
        chk("pp_valid", 32'(out_valid), 1);
        chk("pp_head2", 32'(out_tag), 11);
        repeat (2) tick();
        chk("pp_empty", 32'(out_valid), 0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) send(2'b10, 5'(16 + i), rand_fp(), rand_fp());
        drain();

        // Unexpected return while idle
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        chk("err_unexp_set", 32'(err_unexp), 1);
        chk("unexp_no_push", 32'(out_valid), 0);

        // Reset during feq second pass
        send(2'b00, 5'd20, 32'h40400000, 32'h40400000);
        chk("mid_cmp_valid", 32'(cmp_valid), 1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_cmp_valid", 32'(cmp_valid), 0);
        chk("mid_rst_cmp_x2", cmp_x2, 0);
        chk("mid_rst_errs", {30'b0, err_unexp, err_illegal}, 0);
        rst = 1'b0;
        tick();
        chk("stale_ret_dropped", 32'(err_unexp), 0);
        chk("stale_ret_no_push", 32'(out_valid), 0);
        send(2'b10, 5'd21, 32'h3F800000, 32'h40000000);
        drain();
        chk("mid_err_unexp", 32'(err_unexp), 0);

        // Random traffic with a random consumer
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            n = $urandom_range(0, 15);
            rop = (n < 5) ? 2'b00 : (n < 10) ? 2'b01 : (n < 15) ? 2'b10 : 2'b11;
            ra = rand_fp();
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 32'h8000_0000;
                default: rb = rand_fp();
            endcase
            send(rop, 5'($urandom_range(0, 31)), ra, rb);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_err_unexp", 32'(err_unexp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
